// File: rtl/data_mem_responder_pkg.sv
// Shared types and constants for the data-memory responder.
//   data_size_e : access size encoding carried on reqSize
//   state_e     : responder FSM state encoding
//   mem_req_t   : request fields latched at acceptance
package data_mem_responder_pkg;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned LANES = XLEN / 8;
   localparam int unsigned CNT_W = 4;

   typedef enum logic [1:0] {
      SizeByte = 2'b00,
      SizeHalf = 2'b01,
      SizeWord = 2'b10,
      SizeBad  = 2'b11
   } data_size_e;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StWait = 2'd1,
      StResp = 2'd2
   } state_e;

   typedef struct packed {
      logic             write;
      data_size_e       size;
      logic             uns;
      logic [XLEN-1:0]  addr;
      logic [XLEN-1:0]  wdata;
   } mem_req_t;

   // Misaligned half/word or the reserved size encoding.
   function automatic logic access_err(input data_size_e size, input logic [1:0] addr_lo);
      logic err;
      err = 1'b0;
      case (size)
         SizeByte: err = 1'b0;
         SizeHalf: err = addr_lo[0];
         SizeWord: err = (addr_lo != 2'b00);
         default:  err = 1'b1;
      endcase
      return err;
   endfunction

endpackage

// File: rtl/data_mem_array.sv
// Synchronous single-port word array with per-byte write mask.
//   clk     : clock
//   we_i    : write enable
//   wmask_i : byte-lane write mask
//   idx_i   : word index
//   wdata_i : lane-replicated write data
//   rdata_o : word at idx_i, registered (old data on a write cycle)
// Storage is not reset; contents may be preloaded externally on mem.
module data_mem_array
   import data_mem_responder_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 256
) (
   input  logic                           clk,
   input  logic                           we_i,
   input  logic [LANES-1:0]               wmask_i,
   input  logic [$clog2(DEPTH_WORDS)-1:0] idx_i,
   input  logic [XLEN-1:0]                wdata_i,
   output logic [XLEN-1:0]                rdata_o
);

   logic [XLEN-1:0] mem [DEPTH_WORDS];

   // Masked byte write plus registered read.
   always_ff @(posedge clk) begin
      if (we_i) begin
         for (int b = 0; b < int'(LANES); b++) begin
            if (wmask_i[b]) begin
               mem[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
         end
      end
      rdata_o <= mem[idx_i];
   end

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle load/store responder for the MEM stage.
//   clk, reset  : clock, async active-high reset
//   reqValid    : request present (accepted when reqReady)
//   reqWrite    : 1 store, 0 load
//   reqSize     : 00 byte, 01 half, 10 word, 11 illegal
//   reqUnsigned : load zero-extend (1) or sign-extend (0)
//   reqAddr     : byte address (wraps modulo DEPTH_WORDS words)
//   reqWData    : right-aligned store data
//   reqReady    : idle, can accept
//   respValid   : one-cycle result pulse
//   respRData   : extended load data; 0 for stores and errors
//   respErr     : misaligned or illegal size
//   stall       : hold the pipeline while a request is pending
// DEPTH_WORDS must be a power of two >= 4; LATENCY in 1..15.
module data_mem_responder
   import data_mem_responder_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 256,
   parameter int unsigned LATENCY     = 2
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            reqValid,
   input  logic            reqWrite,
   input  logic [1:0]      reqSize,
   input  logic            reqUnsigned,
   input  logic [XLEN-1:0] reqAddr,
   input  logic [XLEN-1:0] reqWData,
   output logic            reqReady,
   output logic            respValid,
   output logic [XLEN-1:0] respRData,
   output logic            respErr,
   output logic            stall
);

   localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   mem_req_t          req_q, req_d;
   logic              resp_valid_q, resp_valid_d;
   logic [XLEN-1:0]   resp_rdata_q, resp_rdata_d;
   logic              resp_err_q, resp_err_d;

   logic              mem_we_c;
   logic [LANES-1:0]  wmask_c;
   logic [XLEN-1:0]   wdata_c;
   logic [XLEN-1:0]   load_c;
   logic [7:0]        ld_byte_c;
   logic [15:0]       ld_half_c;
   logic [IDX_W-1:0]  arr_idx_c;
   logic [XLEN-1:0]   arr_rdata;
   logic              err_c;
   logic              unused_addr_c;

   // Upper address bits are deliberately ignored (address wrap).
   assign unused_addr_c = ^req_q.addr[XLEN-1:IDX_W+2];

   assign err_c = access_err(req_q.size, req_q.addr[1:0]);

   // In IDLE the array reads the incoming address so the word is already
   // registered by the time a LATENCY=1 request reaches its response edge.
   assign arr_idx_c = (state_q == StIdle) ? reqAddr[IDX_W+1:2] : req_q.addr[IDX_W+1:2];

   data_mem_array #(
      .DEPTH_WORDS (DEPTH_WORDS)
   ) u_array (
      .clk     (clk),
      .we_i    (mem_we_c),
      .wmask_i (wmask_c),
      .idx_i   (arr_idx_c),
      .wdata_i (wdata_c),
      .rdata_o (arr_rdata)
   );

   // Store lane mask/replication and load lane select with extension.
   always_comb begin
      wmask_c   = '0;
      wdata_c   = req_q.wdata;
      load_c    = '0;
      ld_byte_c = 8'(arr_rdata >> {req_q.addr[1:0], 3'b000});
      ld_half_c = req_q.addr[1] ? arr_rdata[31:16] : arr_rdata[15:0];
      case (req_q.size)
         SizeByte: begin
            wmask_c = LANES'(4'b0001 << req_q.addr[1:0]);
            wdata_c = {4{req_q.wdata[7:0]}};
            load_c  = {{24{ld_byte_c[7] & ~req_q.uns}}, ld_byte_c};
         end
         SizeHalf: begin
            wmask_c = req_q.addr[1] ? 4'b1100 : 4'b0011;
            wdata_c = {2{req_q.wdata[15:0]}};
            load_c  = {{16{ld_half_c[15] & ~req_q.uns}}, ld_half_c};
         end
         SizeWord: begin
            wmask_c = 4'b1111;
            load_c  = arr_rdata;
         end
         default: begin
            wmask_c = '0;
         end
      endcase
   end

   // State and response registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= StIdle;
         cnt_q        <= '0;
         req_q        <= '0;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= '0;
         resp_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         req_q        <= req_d;
         resp_valid_q <= resp_valid_d;
         resp_rdata_q <= resp_rdata_d;
         resp_err_q   <= resp_err_d;
      end
   end

   // Next-state logic: accept in IDLE, count down in WAIT, pulse in RESP.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      req_d        = req_q;
      resp_valid_d = 1'b0;
      resp_rdata_d = resp_rdata_q;
      resp_err_d   = resp_err_q;
      mem_we_c     = 1'b0;
      case (state_q)
         StIdle: begin
            if (reqValid) begin
               req_d.write = reqWrite;
               req_d.size  = data_size_e'(reqSize);
               req_d.uns   = reqUnsigned;
               req_d.addr  = reqAddr;
               req_d.wdata = reqWData;
               cnt_d       = CNT_W'(LATENCY - 1);
               state_d     = StWait;
            end
         end
         StWait: begin
            if (cnt_q == '0) begin
               state_d      = StResp;
               resp_valid_d = 1'b1;
               resp_err_d   = err_c;
               resp_rdata_d = (req_q.write || err_c) ? '0 : load_c;
               mem_we_c     = req_q.write & ~err_c;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         StResp: begin
            state_d      = StIdle;
            resp_rdata_d = '0;
            resp_err_d   = 1'b0;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   assign reqReady  = (state_q == StIdle);
   assign stall     = ((state_q == StIdle) & reqValid) | (state_q == StWait);
   assign respValid = resp_valid_q;
   assign respRData = resp_rdata_q;
   assign respErr   = resp_err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench: a driver issues requests and queues the expected
// response (value, error, arrival cycle); a monitor checks every respValid.
module tb_data_mem_responder;

   localparam int unsigned DEPTH = 256;
   localparam int unsigned LAT   = 2;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        reqValid = 1'b0;
   logic        reqWrite = 1'b0;
   logic [1:0]  reqSize = 2'b00;
   logic        reqUnsigned = 1'b0;
   logic [31:0] reqAddr = '0;
   logic [31:0] reqWData = '0;
   logic        reqReady;
   logic        respValid;
   logic [31:0] respRData;
   logic        respErr;
   logic        stall;

   always #5 clk = ~clk;

   data_mem_responder #(
      .DEPTH_WORDS (DEPTH),
      .LATENCY     (LAT)
   ) u_dut (
      .clk         (clk),
      .reset       (reset),
      .reqValid    (reqValid),
      .reqWrite    (reqWrite),
      .reqSize     (reqSize),
      .reqUnsigned (reqUnsigned),
      .reqAddr     (reqAddr),
      .reqWData    (reqWData),
      .reqReady    (reqReady),
      .respValid   (respValid),
      .respRData   (respRData),
      .respErr     (respErr),
      .stall       (stall)
   );

   typedef struct {
      logic [31:0] rd;
      logic        err;
      int          cyc;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;

   // Reference memory as a flat byte array addressed modulo its size.
   bit [7:0] mb [DEPTH*4];

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=0x%08h required=0x%08h (t=%0t)", name, act, req, $time);
      end
   endfunction

   function automatic void model_access(input bit wr, input bit [1:0] sz, input bit uns,
                                        input bit [31:0] a, input bit [31:0] wd,
                                        output bit [31:0] rd, output bit err);
      int     n;
      int     base;
      longint v;
      n    = 1 << sz;
      base = int'(a % (DEPTH*4));
      rd   = '0;
      v    = 0;
      err  = (sz == 2'd3) || ((a % n) != 0);
      if (err) return;
      for (int i = 0; i < n; i++) begin
         if (wr) mb[base+i] = 8'(wd >> (8*i));
         else    v += longint'(mb[base+i]) << (8*i);
      end
      if (!wr) begin
         if (!uns && v >= (longint'(1) << (8*n-1))) v -= longint'(1) << (8*n);
         rd = 32'(v);
      end
   endfunction

   function automatic bit [31:0] model_word(input bit [31:0] a);
      int base;
      base = int'((a % (DEPTH*4)) & ~32'd3);
      return {mb[base+3], mb[base+2], mb[base+1], mb[base]};
   endfunction

   task automatic wait_ready();
      int n = 0;
      @(negedge clk);
      while (!reqReady && n < 64) begin
         @(negedge clk);
         n++;
      end
      if (!reqReady) chk("ready_timeout", 32'(reqReady), 32'd1);
   endtask

   // Issue one request; expectation comes from the model unless overridden.
   task automatic do_req(input bit wr, input bit [1:0] sz, input bit uns,
                         input bit [31:0] a, input bit [31:0] wd,
                         input bit use_exp, input bit [31:0] exp_rd, input bit exp_err);
      bit [31:0] m_rd;
      bit        m_err;
      exp_t      e;
      wait_ready();
      reqWrite    = wr;
      reqSize     = sz;
      reqUnsigned = uns;
      reqAddr     = a;
      reqWData    = wd;
      reqValid    = 1'b1;
      #1;
      chk("stall_idle_req", 32'(stall), 32'd1);
      model_access(wr, sz, uns, a, wd, m_rd, m_err);
      e.rd  = use_exp ? exp_rd  : m_rd;
      e.err = use_exp ? exp_err : m_err;
      e.cyc = cyc + 1 + int'(LAT);
      sb.push_back(e);
      @(posedge clk);
      #1;
      reqValid    = 1'b0;
      reqWrite    = 1'($urandom);
      reqSize     = 2'($urandom);
      reqUnsigned = 1'($urandom);
      reqAddr     = $urandom;
      reqWData    = $urandom;
   endtask

   // Monitor: every response must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (!reset && respValid) begin
         if (sb.size() == 0) begin
            chk("unexpected_resp", 32'(respValid), 32'd0);
         end else begin
            mon_e = sb.pop_front();
            chk("resp_cycle", 32'(cyc), 32'(mon_e.cyc));
            chk("resp_rdata", respRData, mon_e.rd);
            chk("resp_err", 32'(respErr), 32'(mon_e.err));
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      bit [31:0] old_w;
      bit [1:0]  sz;
      bit [31:0] a;
      int        r;
      int        n;

      #1 reset = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("rst_ready", 32'(reqReady), 32'd1);
      chk("rst_valid", 32'(respValid), 32'd0);
      chk("rst_rdata", respRData, 32'd0);
      chk("rst_err", 32'(respErr), 32'd0);
      chk("rst_stall", 32'(stall), 32'd0);
      reset = 1'b0;

      // Give every word a known value.
      for (int i = 0; i < int'(DEPTH); i++) do_req(1'b1, 2'd2, 1'b0, 32'(i*4), $urandom, 1'b0, '0, 1'b0);

      // Word store/load with stall and latency profile.
      do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 1'b1, 32'h0, 1'b0);
      do_req(1'b0, 2'd2, 1'b0, 32'h10, $urandom, 1'b1, 32'hDEADBEEF, 1'b0);
      @(negedge clk);
      chk("stall_wait1", 32'(stall), 32'd1);
      chk("ready_busy", 32'(reqReady), 32'd0);
      @(negedge clk);
      chk("stall_wait2", 32'(stall), 32'd1);
      @(negedge clk);
      chk("stall_resp", 32'(stall), 32'd0);
      chk("resp_pulse", 32'(respValid), 32'd1);

      // Byte lanes and extension.
      do_req(1'b1, 2'd0, 1'b0, 32'h13, 32'h00000080, 1'b1, 32'h0, 1'b0);
      do_req(1'b0, 2'd0, 1'b0, 32'h13, '0, 1'b1, 32'hFFFFFF80, 1'b0);
      do_req(1'b0, 2'd0, 1'b1, 32'h13, '0, 1'b1, 32'h00000080, 1'b0);
      do_req(1'b0, 2'd2, 1'b0, 32'h10, '0, 1'b1, 32'h80ADBEEF, 1'b0);

      // Half lanes.
      do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'h1234ABCD, 1'b1, 32'h0, 1'b0);
      do_req(1'b0, 2'd1, 1'b0, 32'h12, '0, 1'b1, 32'h00001234, 1'b0);
      do_req(1'b0, 2'd1, 1'b0, 32'h10, '0, 1'b1, 32'hFFFFABCD, 1'b0);

      // Error cases leave memory untouched.
      do_req(1'b0, 2'd2, 1'b0, 32'h06, '0, 1'b1, 32'h0, 1'b1);
      do_req(1'b1, 2'd1, 1'b0, 32'h05, 32'hFFFFFFFF, 1'b1, 32'h0, 1'b1);
      do_req(1'b0, 2'd3, 1'b0, 32'h10, '0, 1'b1, 32'h0, 1'b1);
      do_req(1'b1, 2'd3, 1'b0, 32'h10, 32'hFFFFFFFF, 1'b1, 32'h0, 1'b1);
      do_req(1'b0, 2'd2, 1'b0, 32'h10, '0, 1'b1, 32'h1234ABCD, 1'b0);
      do_req(1'b0, 2'd2, 1'b0, 32'h04, '0, 1'b0, '0, 1'b0);

      // Reset during WAIT of a store drops it; reset releasing with a
      // request pending accepts it on the first clean edge.
      old_w = model_word(32'h20);
      wait_ready();
      reqWrite = 1'b1; reqSize = 2'd2; reqUnsigned = 1'b0;
      reqAddr = 32'h20; reqWData = 32'h00000055; reqValid = 1'b1;
      @(posedge clk);
      #1 reqValid = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("midrst_ready", 32'(reqReady), 32'd1);
      chk("midrst_valid", 32'(respValid), 32'd0);
      reqWrite = 1'b0; reqSize = 2'd2; reqAddr = 32'h20; reqValid = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      begin
         exp_t e;
         e.rd = old_w; e.err = 1'b0; e.cyc = cyc + 1 + int'(LAT);
         sb.push_back(e);
      end
      @(posedge clk);
      #1 reqValid = 1'b0;

      // Address wrap.
      do_req(1'b1, 2'd2, 1'b0, 32'h400, 32'hA5A50F0F, 1'b1, 32'h0, 1'b0);
      do_req(1'b0, 2'd2, 1'b0, 32'h000, '0, 1'b1, 32'hA5A50F0F, 1'b0);

      // Randomized traffic against the model.
      for (int k = 0; k < 300; k++) begin
         r  = $urandom_range(0, 9);
         sz = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
         a  = $urandom;
         if ($urandom_range(0, 3) != 0 && sz != 2'd3) a = a & ~((32'd1 << sz) - 32'd1);
         do_req(1'($urandom), sz, 1'($urandom), a, $urandom, 1'b0, '0, 1'b0);
      end

      n = 0;
      while (sb.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("drain", 32'(sb.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Multi-cycle data-memory responder serving the load/store requests the core's MEM stage issues, replacing the combinational data RAM model. It accepts one request at a time over a valid/ready handshake, performs byte/half/word access with byte-lane masking and load sign/zero extension, and returns the result after a fixed latency. While a request is pending it asserts a stall toward the locker unit so the pipeline holds ALU_MEM/MEM_WB.

## Interface
- `DEPTH_WORDS`, 256: number of 32-bit words in storage; power of two, ≥ 4.
- `LATENCY`, 2: number of WAIT cycles between acceptance and response; legal range 1–15.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `reqValid` input 1: request present.
- `reqWrite` input 1: 1 = store, 0 = load.
- `reqSize` input 2: 00 byte, 01 half, 10 word, 11 illegal.
- `reqUnsigned` input 1: loads only; 1 = zero-extend, 0 = sign-extend.
- `reqAddr` input 32: byte address.
- `reqWData` input 32: store data, right-aligned (byte in [7:0], half in [15:0]).
- `reqReady` output 1: responder can accept; high only in IDLE.
- `respValid` output 1: one-cycle pulse, result valid.
- `respRData` output 32: load result, extended; 0 for stores and errors.
- `respErr` output 1: qualified by `respValid`; misaligned access or illegal size.
- `stall` output 1: hold pipeline; to locker unit.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: `reqReady`=1. On `reqValid`, latch write/size/unsigned/addr/wdata and go to WAIT; the counter loads `LATENCY`-1.
- WAIT: decrement the counter; at 0 go to RESP. On that transition edge: a store writes the masked lanes; a load captures the word and extends it into `respRData`.
- RESP: `respValid`=1 for one cycle, then IDLE. Requests are not accepted in RESP.
- Word index is `reqAddr[log2(DEPTH_WORDS)+1:2]`. Upper address bits are ignored, so addresses wrap modulo the depth.
- Lanes:
  - byte: lane `addr[1:0]`, data replicated to all lanes, write mask one-hot.
  - half: lane `addr[1]`×2, mask 0011 or 1100.
  - word: mask 1111.
- Load extension: byte extends from bit 7 of the selected lane, half from bit 15.
- Error cases: half with `addr[0]`=1, word with `addr[1:0]`≠0, or size 11. Behaviour on error: no array write, `respErr`=1, `respRData`=0, full latency still observed.
- `stall` = (IDLE & `reqValid`) | WAIT. It is low in RESP so the pipeline advances on the RESP edge with data valid.
- Storage is not cleared by reset; contents are preloadable with `$readmemb` on the array.

## Timing
- Reset values: state IDLE, `reqReady`=1, `respValid`=0, `respRData`=0, `respErr`=0, `stall`=0 (absent `reqValid`), counter 0.
- Acceptance at edge N: WAIT occupies cycles N+1 … N+LATENCY, `respValid` is high in cycle N+LATENCY+1, and the next acceptance can happen at edge N+LATENCY+2.
- Request inputs are sampled only at the acceptance edge; later changes are ignored.
- Reset asserted mid-WAIT or mid-RESP: the FSM returns to IDLE immediately, any pending store is dropped, and there is no `respValid`.
- Reset releasing while `reqValid`=1: the request is accepted on the first rising edge with `reset` low.
- A store followed by a load to the same word: the load returns the stored data, because the write completes before the load's acceptance.

## Structure
- The size encodings (`SizeByte`/`SizeHalf`/`SizeWord`), the FSM state encodings, and the bus-width macros go in the shared define header alongside `DataSize`.
- One sub-module, `data_mem_array`: a synchronous single-port word array with a 4-bit byte write mask, parameterised by depth.
- Lane alignment, extension, error detection and the FSM live in `data_mem_responder`.

## Test plan
- Reset, then word store 0xDEADBEEF to 0x10 and word load from 0x10 → `respValid` at acceptance+3 (LATENCY=2), `respRData`=0xDEADBEEF, `respErr`=0. `stall` is high for 3 cycles.
- Byte store 0x80 to 0x13, then signed byte load from 0x13 → 0xFFFFFF80. Unsigned load → 0x00000080. A word load from 0x10 → 0x80ADBEEF.
- Half load from 0x12 with the word holding 0x1234ABCD: signed → 0x00001234; signed from 0x10 → 0xFFFFABCD.
- Word load from 0x06, half store to 0x05, and size 11 → each gives `respErr`=1 and `respRData`=0, and memory is unchanged when reread.
- Assert `reset` during WAIT of a store 0x55 to 0x20 → no `respValid`, and a subsequent load of 0x20 returns the old value.
- Address wrap: with DEPTH_WORDS=256, a store to 0x400 followed by a load from 0x000 → the stored value.
